serial_and_reducer: RTL and testbench

- Bit-serial counterpart of the parallel cascade AND reduction.
- Accepts a frame of LENGTH bits, one per cycle, over a valid/ready handshake.
- Reduces the bits with a running AND and presents the 1-bit result on a valid/ready output handshake.
- Used where an operand arrives serially rather than as a parallel vector.

---
 rtl/serial_and_reducer.sv | 146 ++++++++++++++
 tb/tb_serial_and_reducer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_and_reducer.sv
// serial_and_reducer: bit-serial AND reduction of a LENGTH-bit frame.
//
// Bits arrive one per cycle over a valid/ready handshake, with bit 0 first.
// Each accepted bit is ANDed into a running accumulator. The 1-bit result is
// then offered on a valid/ready output handshake. Between frames there is one
// bubble cycle, because in_ready rises only after the result has been taken.
//
// Optional build macro: SERIAL_AND_FIRST_ZERO_EN adds the first_zero output,
// which holds the index of the first 0 bit, or LENGTH when every bit was 1.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort of the frame in progress; overrides any transfer
//   in_valid   in_bit is valid this cycle
//   in_ready   block can accept a bit this cycle
//   in_bit     serial data bit
//   out_valid  y is valid
//   out_ready  downstream accepts y
//   y          AND of all LENGTH bits of the completed frame
//   bit_cnt    number of bits accepted in the current frame
//   first_zero (macro only) index of the first 0 bit, or LENGTH when none
module serial_and_reducer #(
  parameter int unsigned LENGTH = 8,
  localparam int unsigned CNT_W = $clog2(LENGTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic [CNT_W-1:0] bit_cnt
`ifdef SERIAL_AND_FIRST_ZERO_EN
  ,
  output logic [CNT_W-1:0] first_zero
`endif
);

  localparam logic StAccum = 1'b0;
  localparam logic StDone  = 1'b1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] CntLen  = CNT_W'(LENGTH);

  logic             state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             y_q, y_d;

`ifdef SERIAL_AND_FIRST_ZERO_EN
  logic             seen_zero_q, seen_zero_d;
  logic [CNT_W-1:0] zero_idx_q, zero_idx_d;
  logic [CNT_W-1:0] first_zero_q, first_zero_d;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
`ifdef SERIAL_AND_FIRST_ZERO_EN
    seen_zero_d  = seen_zero_q;
    zero_idx_d   = zero_idx_q;
    first_zero_d = first_zero_q;
`endif
    if (clr) begin
      // Abort wins over both handshakes. y and first_zero keep their old values.
      state_d     = StAccum;
      acc_d       = 1'b1;
      cnt_d       = '0;
      out_valid_d = 1'b0;
`ifdef SERIAL_AND_FIRST_ZERO_EN
      seen_zero_d = 1'b0;
`endif
    end else if (state_q == StAccum) begin
      if (in_valid) begin
        acc_d = acc_q & in_bit;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIAL_AND_FIRST_ZERO_EN
        if (!in_bit && !seen_zero_q) begin
          seen_zero_d = 1'b1;
          zero_idx_d  = cnt_q;
        end
`endif
        if (cnt_q == CntLast) begin
          y_d         = acc_q & in_bit;
          out_valid_d = 1'b1;
          state_d     = StDone;
`ifdef SERIAL_AND_FIRST_ZERO_EN
          // If the final bit is the first zero, it is not yet in zero_idx_q.
          first_zero_d = seen_zero_q ? zero_idx_q : (in_bit ? CntLen : cnt_q);
`endif
        end
      end
    end else if (out_ready) begin
      state_d     = StAccum;
      acc_d       = 1'b1;
      cnt_d       = '0;
      out_valid_d = 1'b0;
`ifdef SERIAL_AND_FIRST_ZERO_EN
      seen_zero_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      acc_q       <= 1'b1;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      y_q         <= 1'b0;
`ifdef SERIAL_AND_FIRST_ZERO_EN
      seen_zero_q  <= 1'b0;
      zero_idx_q   <= '0;
      first_zero_q <= CntLen;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
`ifdef SERIAL_AND_FIRST_ZERO_EN
      seen_zero_q  <= seen_zero_d;
      zero_idx_q   <= zero_idx_d;
      first_zero_q <= first_zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign bit_cnt   = cnt_q;
`ifdef SERIAL_AND_FIRST_ZERO_EN
  assign first_zero = first_zero_q;
`endif

endmodule

// File: tb/tb_serial_and_reducer.sv
// Bench for serial_and_reducer. Two instances are used: LENGTH=8 (index 0)
// and LENGTH=1 (index 1). Each one is checked against a queue-based frame model.
module tb_serial_and_reducer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv[2], ib[2], ordy[2], cl[2];
  logic       ir[2], ov[2], yv[2];
  logic [3:0] cnt8;
  logic [0:0] cnt1;
`ifdef SERIAL_AND_FIRST_ZERO_EN
  logic [3:0] fz8;
  logic [0:0] fz1;
`endif

  serial_and_reducer #(.LENGTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(cl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_bit(ib[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .y(yv[0]), .bit_cnt(cnt8)
`ifdef SERIAL_AND_FIRST_ZERO_EN
    , .first_zero(fz8)
`endif
  );

  serial_and_reducer #(.LENGTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(cl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_bit(ib[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .y(yv[1]), .bit_cnt(cnt1)
`ifdef SERIAL_AND_FIRST_ZERO_EN
    , .first_zero(fz1)
`endif
  );

  int checks = 0;
  int errors = 0;
  int len[2] = '{8, 1};

  // Reference model: accepted bits of the current frame, and the last result.
  bit mq[2][$];
  bit m_done[2];
  bit m_y[2];
  int m_fz[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_done[i] = 1'b0;
      m_y[i]    = 1'b0;
      m_fz[i]   = len[i];
    end
  endfunction

  function automatic void model_step(int i);
    if (cl[i]) begin
      mq[i].delete();
      m_done[i] = 1'b0;
    end else if (!m_done[i]) begin
      if (iv[i]) begin
        mq[i].push_back(ib[i]);
        if (mq[i].size() == len[i]) begin
          m_done[i] = 1'b1;
          m_y[i]    = 1'b1;
          m_fz[i]   = len[i];
          for (int k = 0; k < len[i]; k++) begin
            if (!mq[i][k]) begin
              m_y[i] = 1'b0;
              if (m_fz[i] == len[i]) m_fz[i] = k;
            end
          end
        end
      end
    end else if (ordy[i]) begin
      m_done[i] = 1'b0;
      mq[i].delete();
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cnt_of(int i);
    return (i == 0) ? int'(cnt8) : int'(cnt1);
  endfunction

`ifdef SERIAL_AND_FIRST_ZERO_EN
  function automatic int fz_of(int i);
    return (i == 0) ? int'(fz8) : int'(fz1);
  endfunction
`endif

  task automatic check_model(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s L%0d in_ready", tag, len[i]), int'(ir[i]), int'(!m_done[i]));
      chk($sformatf("%s L%0d out_valid", tag, len[i]), int'(ov[i]), int'(m_done[i]));
      chk($sformatf("%s L%0d y", tag, len[i]), int'(yv[i]), int'(m_y[i]));
      chk($sformatf("%s L%0d bit_cnt", tag, len[i]), cnt_of(i), mq[i].size());
`ifdef SERIAL_AND_FIRST_ZERO_EN
      chk($sformatf("%s L%0d first_zero", tag, len[i]), fz_of(i), m_fz[i]);
`endif
    end
  endtask

  task automatic drive(int i, bit v, bit b, bit r, bit c);
    iv[i] = v; ib[i] = b; ordy[i] = r; cl[i] = c;
  endtask

  task automatic tick(string tag);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit v, b, r;
    bit e_ir, e_ov, e_y;
    int e_cnt;
  } vec_t;
  vec_t tbl[17];

  initial begin
    // Frame 1,1,0,1,1,1,1,1 with in_valid on every other cycle. The idle
    // cycles drive in_bit=0, which must be ignored. y holds 1 from the
    // previous frame until this frame completes.
    tbl[0]  = '{1, 1, 0, 1, 0, 1, 1};  tbl[1]  = '{0, 0, 0, 1, 0, 1, 1};
    tbl[2]  = '{1, 1, 0, 1, 0, 1, 2};  tbl[3]  = '{0, 0, 0, 1, 0, 1, 2};
    tbl[4]  = '{1, 0, 0, 1, 0, 1, 3};  tbl[5]  = '{0, 0, 0, 1, 0, 1, 3};
    tbl[6]  = '{1, 1, 0, 1, 0, 1, 4};  tbl[7]  = '{0, 0, 0, 1, 0, 1, 4};
    tbl[8]  = '{1, 1, 0, 1, 0, 1, 5};  tbl[9]  = '{0, 0, 0, 1, 0, 1, 5};
    tbl[10] = '{1, 1, 0, 1, 0, 1, 6};  tbl[11] = '{0, 0, 0, 1, 0, 1, 6};
    tbl[12] = '{1, 1, 0, 1, 0, 1, 7};  tbl[13] = '{0, 0, 0, 1, 0, 1, 7};
    tbl[14] = '{1, 1, 0, 0, 1, 0, 8};  tbl[15] = '{0, 0, 0, 0, 1, 0, 8};
    tbl[16] = '{0, 0, 1, 1, 0, 0, 0};

    for (int i = 0; i < 2; i++) drive(i, 0, 0, 0, 0);
    model_reset();
    #12;
    check_model("reset");
    rst_n = 1'b1;

    // All-ones frame with in_valid held: one result cycle, then in_ready again.
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 1, 1, 0);
      tick("ones");
    end
    chk("ones out_valid", int'(ov[0]), 1);
    chk("ones y", int'(yv[0]), 1);
    tick("ones hs");
    chk("ones ready after hs", int'(ir[0]), 1);
    chk("ones out_valid one cycle", int'(ov[0]), 0);
    drive(0, 0, 0, 0, 0);

    // Table-driven: frame with in_valid toggling.
    for (int r = 0; r < 17; r++) begin
      drive(0, tbl[r].v, tbl[r].b, tbl[r].r, 0);
      tick($sformatf("tbl%0d", r));
      chk($sformatf("tbl%0d in_ready", r), int'(ir[0]), int'(tbl[r].e_ir));
      chk($sformatf("tbl%0d out_valid", r), int'(ov[0]), int'(tbl[r].e_ov));
      chk($sformatf("tbl%0d y", r), int'(yv[0]), int'(tbl[r].e_y));
      chk($sformatf("tbl%0d bit_cnt", r), int'(cnt8), tbl[r].e_cnt);
`ifdef SERIAL_AND_FIRST_ZERO_EN
      if (r == 14) chk("tbl first_zero", int'(fz8), 2);
`endif
    end

    // Backpressure: the result is held for 5 cycles and extra bits are ignored.
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 1, 0, 0);
      tick("bp fill");
    end
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, k[0], 0, 0);
      tick("bp hold");
      chk("bp in_ready", int'(ir[0]), 0);
      chk("bp out_valid", int'(ov[0]), 1);
      chk("bp y", int'(yv[0]), 1);
      chk("bp bit_cnt", int'(cnt8), 8);
    end
    drive(0, 0, 0, 1, 0);
    tick("bp release");

    // clr after 5 bits, with in_valid high in the same cycle.
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 1, 0);
      tick("clr pre");
    end
    drive(0, 1, 1, 1, 1);
    tick("clr");
    chk("clr bit_cnt", int'(cnt8), 0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 1, 1, 0);
      tick("clr post");
    end
    chk("clr post y", int'(yv[0]), 1);
    chk("clr post out_valid", int'(ov[0]), 1);
    drive(0, 0, 0, 1, 0);
    tick("clr hs");

    // Asynchronous reset mid-frame (bit_cnt=3) and again in DONE.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0);
      tick("rst pre");
    end
    chk("rst pre bit_cnt", int'(cnt8), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid bit_cnt", int'(cnt8), 0);
    model_reset();
    check_model("rst mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 1, 0, 0);
      tick("rst fill");
    end
    chk("rst done out_valid", int'(ov[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst done in_ready", int'(ir[0]), 1);
    chk("rst done y", int'(yv[0]), 0);
    model_reset();
    check_model("rst done");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 1, 1, 0);
      tick("rst fresh");
    end
    chk("rst fresh y", int'(yv[0]), 1);
    drive(0, 0, 0, 1, 0);
    tick("rst fresh hs");

    // LENGTH=1: bit stream 0,1 with one bubble cycle between the two frames.
    drive(1, 1, 0, 1, 0);
    tick("l1 a");
    chk("l1 first y", int'(yv[1]), 0);
    chk("l1 first out_valid", int'(ov[1]), 1);
`ifdef SERIAL_AND_FIRST_ZERO_EN
    chk("l1 first first_zero", int'(fz1), 0);
`endif
    drive(1, 1, 1, 1, 0);
    tick("l1 bubble");
    chk("l1 bubble in_ready", int'(ir[1]), 1);
    chk("l1 bubble bit_cnt", int'(cnt1), 0);
    tick("l1 b");
    chk("l1 second y", int'(yv[1]), 1);
`ifdef SERIAL_AND_FIRST_ZERO_EN
    chk("l1 second first_zero", int'(fz1), 1);
`endif
    drive(1, 0, 0, 1, 0);
    tick("l1 hs");

    // Random traffic on both instances, checked against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0);
      end
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
